// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM states, phase
// encodings, ALU function codes and datapath widths.
package alu_seq_pkg;

    localparam int unsigned OPW = 6;   // operand width
    localparam int unsigned FXW = 3;   // function-code width
    localparam int unsigned PHW = 2;   // phase indicator width
    localparam int unsigned FLW = 3;   // latched flag width

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_F    = 3'd2,
        S_WAIT = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [PHW-1:0] PH_A    = 2'd0;
    localparam logic [PHW-1:0] PH_B    = 2'd1;
    localparam logic [PHW-1:0] PH_F    = 2'd2;
    localparam logic [PHW-1:0] PH_SHOW = 2'd3;

    localparam logic [FXW-1:0] FXN_PASS_A = 3'b000;
    localparam logic [FXW-1:0] FXN_PASS_B = 3'b001;
    localparam logic [FXW-1:0] FXN_NEG_A  = 3'b010;
    localparam logic [FXW-1:0] FXN_NEG_B  = 3'b011;
    localparam logic [FXW-1:0] FXN_LT     = 3'b100;
    localparam logic [FXW-1:0] FXN_XNOR   = 3'b101;
    localparam logic [FXW-1:0] FXN_ADD    = 3'b110;
    localparam logic [FXW-1:0] FXN_SUB    = 3'b111;

    // Latched ALU status, MSB first: {compare, carry, overflow}
    typedef struct packed {
        logic cmp;
        logic c_out;
        logic overflow;
    } alu_flags_t;

    function automatic logic [PHW-1:0] phase_of(input state_t s);
        case (s)
            S_A:     phase_of = PH_A;
            S_B:     phase_of = PH_B;
            S_F:     phase_of = PH_F;
            default: phase_of = PH_SHOW;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted press.
//   clk, rst_n : clock, async active-low reset
//   i_btn      : raw, bouncy, active-high button
//   o_pulse    : one-cycle pulse per accepted 0->1 transition
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [1:0]    r_fill;     // marks when r_sync[1] reflects a real post-reset sample
    logic          r_armed;    // set once the button has been seen released
    logic          r_level;
    logic          r_level_q;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_fill    <= '0;
            r_armed   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_fill    <= {r_fill[0], 1'b1};
            // A button held through reset must be released before it can pulse
            if (r_fill[1] && !r_sync[1])
                r_armed <= 1'b1;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_level_q <= r_level;
            r_pulse   <= r_level & ~r_level_q & r_armed;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front end for the 6-bit ALU: steps through operand A, operand B and the
// function code from one switch bank, then latches the ALU result and flags.
//   clk, rst_n                 : clock, async active-low reset
//   sw, btn_enter, btn_clear   : board switches and raw buttons
//   a_out, b_out, fxn_out      : values driven into the ALU
//   alu_led, alu_bool,
//   alu_c_out, alu_overflow    : ALU combinational outputs
//   result, flags, valid       : latched ALU result/status
//   phase                      : entry phase (0=A, 1=B, 2=FXN, 3=SHOW)
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] sw,
    input  logic           btn_enter,
    input  logic           btn_clear,
    output logic [OPW-1:0] a_out,
    output logic [OPW-1:0] b_out,
    output logic [FXW-1:0] fxn_out,
    input  logic [OPW-1:0] alu_led,
    input  logic           alu_bool,
    input  logic           alu_c_out,
    input  logic           alu_overflow,
    output logic [OPW-1:0] result,
    output logic [FLW-1:0] flags,
    output logic           valid,
    output logic [PHW-1:0] phase
);

    logic w_enter_p;
    logic w_clear_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_enter),
        .o_pulse (w_enter_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_clear),
        .o_pulse (w_clear_p)
    );

    state_t         r_state;
    state_t         w_next_state;
    logic           r_settle;      // S_WAIT has spent its settling cycle
    logic [PHW-1:0] r_phase;

    logic w_cap_a, w_cap_b, w_cap_f, w_latch, w_drop;

    logic [OPW-1:0] r_a, r_b, r_result;
    logic [FXW-1:0] r_fxn;
    alu_flags_t     r_flags;
    logic           r_valid;

    // State register; phase is registered from the next state so it moves with the capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_phase  <= PH_A;
            r_settle <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_phase  <= phase_of(w_next_state);
            r_settle <= (r_state == S_WAIT) && !r_settle && !w_clear_p;
        end
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        w_next_state = r_state;
        if (w_clear_p) begin
            w_next_state = S_A;
        end else begin
            case (r_state)
                S_A:     if (w_enter_p) w_next_state = S_B;
                S_B:     if (w_enter_p) w_next_state = S_F;
                S_F:     if (w_enter_p) w_next_state = S_WAIT;
                S_WAIT:  if (r_settle)  w_next_state = S_SHOW;
                S_SHOW:  if (w_enter_p) w_next_state = S_A;
                default: w_next_state = S_A;
            endcase
        end
    end

    // Datapath strobes decoded from state and pulses
    always_comb begin
        w_cap_a = 1'b0;
        w_cap_b = 1'b0;
        w_cap_f = 1'b0;
        w_latch = 1'b0;
        w_drop  = 1'b0;
        if (!w_clear_p) begin
            case (r_state)
                S_A:     w_cap_a = w_enter_p;
                S_B:     w_cap_b = w_enter_p;
                S_F:     w_cap_f = w_enter_p;
                S_WAIT:  w_latch = r_settle;
                S_SHOW:  w_drop  = w_enter_p;
                default: ;
            endcase
        end
    end

    // Operand capture and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_fxn    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
        end else if (w_clear_p) begin
            r_a      <= '0;
            r_b      <= '0;
            r_fxn    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_cap_a) r_a   <= sw;
            if (w_cap_b) r_b   <= sw;
            if (w_cap_f) r_fxn <= sw[FXW-1:0];
            if (w_latch) begin
                r_result <= alu_led;
                r_flags  <= '{cmp: alu_bool, c_out: alu_c_out, overflow: alu_overflow};
                r_valid  <= 1'b1;
            end
            if (w_drop) r_valid <= 1'b0;
        end
    end

    assign a_out   = r_a;
    assign b_out   = r_b;
    assign fxn_out = r_fxn;
    assign result  = r_result;
    assign flags   = r_flags;
    assign valid   = r_valid;
    assign phase   = r_phase;

endmodule
